// File: rtl/tick_gen.sv
// Programmable tick generator: issues a single-cycle enable strobe every
// period+1 cycles, either for a finite burst or continuously, with pause
// (hold) and abort (stop) control. All outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; tick/done only carry the completion pulse
// RUN     | prescaler counting down, tick issued when it reaches zero
// HOLD    | paused; prescaler frozen until hold drops
module tick_gen #(
    parameter int DIV_WIDTH   = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   hold,
    input  logic [DIV_WIDTH-1:0]   period,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   tick,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]             state;
    logic [DIV_WIDTH-1:0]   presc;
    logic [DIV_WIDTH-1:0]   period_q;
    logic [BURST_WIDTH-1:0] len_q;
    logic [BURST_WIDTH-1:0] cnt;

    // Sequencer: state, prescaler, tick counter, latched config and the
    // registered strobes. The edge that releases HOLD is treated as a normal
    // RUN edge so the pause costs exactly as many cycles as hold was sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            presc    <= '0;
            period_q <= '0;
            len_q    <= '0;
            cnt      <= '0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start together with stop is treated as no request
                    if (start && !stop) begin
                        period_q <= period;
                        len_q    <= burst_len;
                        presc    <= period;
                        cnt      <= '0;
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (hold) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_RUN;
                        if (presc != '0) begin
                            presc <= presc - 1'b1;
                        end else begin
                            tick  <= 1'b1;
                            presc <= period_q;
                            cnt   <= cnt + 1'b1;
                            // len_q of zero means continuous; cnt simply wraps
                            if ((len_q != '0) && (cnt == len_q - 1'b1)) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen. Edge 0 is the rising edge that samples start;
// outputs are sampled 1 time unit after each following edge k and compared
// against hand-computed bitmasks indexed by k.
module tb_tick_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       hold;
    logic [7:0] period;
    logic [3:0] burst_len;
    logic       tick;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    tick_gen #(.DIV_WIDTH(8), .BURST_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .period    (period),
        .burst_len (burst_len),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and compare the three outputs against bit k of the masks.
    task automatic edge_chk(input string sc, input int k, input logic [63:0] tm,
                            input logic [63:0] dm, input logic [63:0] bm);
        @(posedge clk);
        #1;
        chk_eq($sformatf("%s tick@%0d", sc, k), {31'd0, tick}, {31'd0, tm[k]});
        chk_eq($sformatf("%s done@%0d", sc, k), {31'd0, done}, {31'd0, dm[k]});
        chk_eq($sformatf("%s busy@%0d", sc, k), {31'd0, busy}, {31'd0, bm[k]});
    endtask

    task automatic launch(input logic [7:0] per, input logic [3:0] len);
        @(negedge clk);
        period    = per;
        burst_len = len;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [63:0] bit_at(input int k);
        return 64'd1 << k;
    endfunction

    // busy expected on edges 1..last-1 (low from the completion/abort edge on)
    function automatic logic [63:0] busy_to(input int last);
        return (64'd1 << last) - 64'd2;
    endfunction

    initial begin
        logic [63:0] tm;
        logic [63:0] dm;
        logic [63:0] bm;

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        hold      = 1'b0;
        period    = 8'd0;
        burst_len = 4'd0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset tick", {31'd0, tick}, 32'd0);
        chk_eq("reset busy", {31'd0, busy}, 32'd0);
        chk_eq("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // period=3, burst=4: ticks at 4,8,12,16, done with the 4th
        tm = bit_at(4) | bit_at(8) | bit_at(12) | bit_at(16);
        dm = bit_at(16);
        bm = busy_to(16);
        launch(8'd3, 4'd4);
        for (int k = 1; k <= 20; k++) edge_chk("burst4", k, tm, dm, bm);

        // start re-pulsed and period changed mid-burst: no effect
        launch(8'd3, 4'd4);
        for (int k = 1; k <= 20; k++) begin
            edge_chk("relaunch", k, tm, dm, bm);
            if (k == 5) begin
                period = 8'd7;
                start  = 1'b1;
            end
            if (k == 7) start = 1'b0;
            if (k == 9) burst_len = 4'd1;
        end

        // period=0 continuous: tick every cycle past the counter wrap, then stop
        tm = busy_to(21);
        dm = 64'd0;
        bm = busy_to(21);
        launch(8'd0, 4'd0);
        for (int k = 1; k <= 23; k++) begin
            edge_chk("cont", k, tm, dm, bm);
            if (k == 20) stop = 1'b1;
            if (k == 21) stop = 1'b0;
        end

        // period=5, burst=2, hold sampled on edges 2..8: ticks at 13 and 19
        tm = bit_at(13) | bit_at(19);
        dm = bit_at(19);
        bm = busy_to(19);
        launch(8'd5, 4'd2);
        for (int k = 1; k <= 22; k++) begin
            edge_chk("hold", k, tm, dm, bm);
            if (k == 1) hold = 1'b1;
            if (k == 8) hold = 1'b0;
        end

        // period=4, burst=3, stop on the edge of the 3rd tick: no tick, no done
        tm = bit_at(5) | bit_at(10);
        dm = 64'd0;
        bm = busy_to(15);
        launch(8'd4, 4'd3);
        for (int k = 1; k <= 20; k++) begin
            edge_chk("stopwin", k, tm, dm, bm);
            if (k == 14) stop = 1'b1;
            if (k == 15) stop = 1'b0;
        end

        // period=2, burst=5, async reset while tick is high
        launch(8'd2, 4'd5);
        for (int k = 1; k <= 3; k++) edge_chk("rstpre", k, bit_at(3), 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        #2 rst = 1'b0;
        #1;
        chk_eq("async tick", {31'd0, tick}, 32'd0);
        chk_eq("async busy", {31'd0, busy}, 32'd0);
        chk_eq("async done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) edge_chk("postrst", k, 64'd0, 64'd0, 64'd0);
        tm = bit_at(3) | bit_at(6) | bit_at(9) | bit_at(12) | bit_at(15);
        dm = bit_at(15);
        bm = busy_to(15);
        launch(8'd2, 4'd5);
        for (int k = 1; k <= 18; k++) edge_chk("fresh5", k, tm, dm, bm);

        // start together with stop in IDLE stays idle; stop alone is ignored
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) edge_chk("startstop", k, 64'd0, 64'd0, 64'd0);
        stop = 1'b0;

        // boundary: period=0, burst=1 completes on the first edge
        launch(8'd0, 4'd1);
        for (int k = 1; k <= 3; k++) edge_chk("single", k, bit_at(1), bit_at(1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
